cnt_capture_ext: RTL and testbench
==================================

# cnt_capture_ext

Downstream extension stage for the 16-bit up counter with carry-out. It consumes the counter's 16-bit value and its carry-out (CAO) and counts carries in an upper counter, which extends the count to 16+UPPER_W bits. On request it captures a coherent {upper, lower} snapshot into an output register with a valid/ready handshake. It sits between the counter macro and timestamp/event-logging consumers.

## Interface
Parameters:
- UPPER_W, 16, upper counter width; snapshot width is 16+UPPER_W.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- CD  in  1  reset, synchronous, active-high.
- Q_LO  in  16  lower count from the counter (Q15..Q0 bundled, Q_LO[0]=Q0).
- CAO  in  1  carry-out from the counter; high in the cycle the lower count wraps at the next edge.
- CAPT  in  1  capture request, sampled each cycle.
- DOUT  out  16+UPPER_W  captured snapshot {upper, lower}.
- DVALID  out  1  DOUT holds an unconsumed snapshot.
- DREADY  in  1  consumer accepts DOUT when DVALID&&DREADY.
- LOST  out  1  sticky: a capture was dropped.
- CLR_LOST  in  1  clears LOST.
- HI  out  UPPER_W  live upper count.

## Operation
- Upper counter HI: HI <= HI+1 on any edge with CAO=1. It wraps modulo 2^UPPER_W. Without CAO, HI holds.
- Coherence: CAO and Q_LO are pre-edge values, and HI increments on the same edge the lower count wraps. {HI, Q_LO} sampled in any single cycle is therefore a consistent value.
- Capture FSM, two states:
  - EMPTY (DVALID=0): if CAPT, load DOUT <= {HI, Q_LO} (current-cycle values, pre-increment) and go to FULL.
  - FULL (DVALID=1):
    - DREADY&&CAPT: reload DOUT with the new snapshot and stay FULL.
    - DREADY&&!CAPT: go to EMPTY; DOUT holds its last value.
    - !DREADY&&CAPT: drop the request, keep DOUT, set LOST.
    - !DREADY&&!CAPT: hold.
- LOST:
  - Set on a dropped capture.
  - Cleared by CLR_LOST.
  - If set and clear occur in the same cycle, set wins.
- DOUT is stable while DVALID=1 and DREADY=0.

## Timing
- Reset (CD=1 at an edge): HI=0, DOUT=0, DVALID=0, LOST=0, FSM=EMPTY, OVF=0 (if built). Reset overrides CAPT, CAO and CLR_LOST in the same cycle.
- Reset mid-operation discards any pending snapshot. There is no handshake completion across reset.
- Capture latency: CAPT at edge n gives DVALID=1 and DOUT valid after edge n, i.e. in cycle n+1.
- Throughput: one snapshot per cycle when DREADY is held high.
- HI updates one edge after the CAO-high cycle. This is the same edge where Q_LO reads 0.
- CAPT in the CAO-high cycle captures {HI_old, 16'hFFFF}. CAPT in the next cycle captures {HI_old+1, 16'h0000}.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- Macro CNT_CAPTURE_EXT_OVF_EN.
- Defined:
  - Adds output OVF (1 bit) and input CLR_OVF.
  - OVF is sticky, set when HI wraps from all-ones to 0 (CAO=1 with HI=all-ones).
  - Cleared by CLR_OVF; set wins when set and clear coincide.
  - OVF resets to 0.
- Undefined: OVF and CLR_OVF are absent from the port list, and HI wraps silently.

## Structure
- Package cnt_capture_ext_pkg:
  - capture FSM state enum (ST_EMPTY, ST_FULL);
  - constant LO_W=16;
  - function for snapshot width (LO_W+UPPER_W).
- One sub-module, cnt_capture_ext_hi: the UPPER_W-bit carry counter with synchronous clear, increment-on-CAO, and the optional OVF flag. The capture FSM and LOST logic stay in the top module.

## Test plan
- Reset: drive CD=1 for 2 cycles with CAPT=1 and CAO=1 -> HI=0, DVALID=0, LOST=0, DOUT=0.
- Carry: HI=0x0003, Q_LO=0xFFFF, CAO=1 for one cycle -> HI=0x0004 next cycle. Pulse CAPT in the CAO cycle -> DOUT=0x0003FFFF. Pulse CAPT the cycle after -> DOUT=0x00040000.
- Back-pressure: CAPT at Q_LO=0x0010 with DREADY=0, then CAPT again at 0x0012 -> DOUT stays 0x00000010 and LOST=1. Then CLR_LOST -> LOST=0.
- Simultaneous accept and capture: DVALID=1, DREADY=1, CAPT=1 at Q_LO=0x0100 -> DVALID stays 1, DOUT=0x00000100. Next cycle DREADY=1, CAPT=0 -> DVALID=0.
- Overflow (macro defined): HI=0xFFFF, CAO=1 -> HI=0x0000, OVF=1. CLR_OVF together with a second wrap -> OVF stays 1.
- Reset mid-handshake: DVALID=1, DREADY=0, assert CD -> DVALID=0 and DOUT=0 next cycle, and no accept is seen.

Source files
------------

// File: rtl/cnt_capture_ext_pkg.sv
// Shared types and constants for the counter extension / snapshot capture stage.
package cnt_capture_ext_pkg;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } cap_state_e;

    localparam int unsigned LO_W = 16;

    function automatic int unsigned snap_w(input int unsigned upper_w);
        return LO_W + upper_w;
    endfunction

endpackage

// File: rtl/cnt_capture_ext_hi.sv
// Upper carry counter: counts CAO pulses, wraps modulo 2^UPPER_W.
// Optional sticky wrap flag when CNT_CAPTURE_EXT_OVF_EN is defined.
module cnt_capture_ext_hi #(
    parameter int unsigned UPPER_W = 16
) (
    input  logic               CLK,
    input  logic               CD,
    input  logic               CAO,
`ifdef CNT_CAPTURE_EXT_OVF_EN
    input  logic               CLR_OVF,
    output logic               OVF,
`endif
    output logic [UPPER_W-1:0] HI
);

    logic [UPPER_W-1:0] hi_q, hi_d;

    always_comb begin
        hi_d = hi_q;
        if (CAO) hi_d = hi_q + UPPER_W'(1);
    end

    always_ff @(posedge CLK) begin
        if (CD) hi_q <= '0;
        else    hi_q <= hi_d;
    end

    assign HI = hi_q;

`ifdef CNT_CAPTURE_EXT_OVF_EN
    logic ovf_q, ovf_d;

    // A wrap in the same cycle as a clear keeps the flag set.
    always_comb begin
        ovf_d = ovf_q;
        if (CLR_OVF)          ovf_d = 1'b0;
        if (CAO && (&hi_q))   ovf_d = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (CD) ovf_q <= 1'b0;
        else    ovf_q <= ovf_d;
    end

    assign OVF = ovf_q;
`endif

endmodule

// File: rtl/cnt_capture_ext.sv
// Extends the 16-bit counter with an upper carry counter and captures coherent
// {HI, Q_LO} snapshots behind a valid/ready handshake. Optional: CNT_CAPTURE_EXT_OVF_EN.
module cnt_capture_ext
    import cnt_capture_ext_pkg::*;
#(
    parameter int unsigned UPPER_W = 16
) (
    input  logic                           CLK,
    input  logic                           CD,
    input  logic [LO_W-1:0]                Q_LO,
    input  logic                           CAO,
    input  logic                           CAPT,
    output logic [snap_w(UPPER_W)-1:0]     DOUT,
    output logic                           DVALID,
    input  logic                           DREADY,
    output logic                           LOST,
    input  logic                           CLR_LOST,
`ifdef CNT_CAPTURE_EXT_OVF_EN
    output logic                           OVF,
    input  logic                           CLR_OVF,
`endif
    output logic [UPPER_W-1:0]             HI
);

    logic [UPPER_W-1:0]          hi_w;
    logic [snap_w(UPPER_W)-1:0]  snap_w_val;
    logic [snap_w(UPPER_W)-1:0]  dout_q;
    cap_state_e                  state_q;
    logic                        lost_q, lost_d;
    logic                        drop;

    cnt_capture_ext_hi #(
        .UPPER_W (UPPER_W)
    ) u_hi (
        .CLK     (CLK),
        .CD      (CD),
        .CAO     (CAO),
`ifdef CNT_CAPTURE_EXT_OVF_EN
        .CLR_OVF (CLR_OVF),
        .OVF     (OVF),
`endif
        .HI      (hi_w)
    );

    // Pre-edge HI and Q_LO always describe the same count, since HI steps on the wrap edge.
    assign snap_w_val = {hi_w, Q_LO};
    assign drop       = (state_q == ST_FULL) && !DREADY && CAPT;

    always_comb begin
        lost_d = lost_q;
        if (CLR_LOST) lost_d = 1'b0;
        if (drop)     lost_d = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (CD) begin
            state_q <= ST_EMPTY;
            dout_q  <= '0;
            lost_q  <= 1'b0;
        end else begin
            lost_q <= lost_d;
            case (state_q)
                ST_EMPTY: begin
                    if (CAPT) begin
                        dout_q  <= snap_w_val;
                        state_q <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (DREADY) begin
                        if (CAPT) dout_q  <= snap_w_val;
                        else      state_q <= ST_EMPTY;
                    end
                end
                default: state_q <= ST_EMPTY;
            endcase
        end
    end

    assign DOUT   = dout_q;
    assign DVALID = (state_q == ST_FULL);
    assign LOST   = lost_q;
    assign HI     = hi_w;

endmodule

// File: tb/tb_cnt_capture_ext.sv
// Directed self-checking bench for cnt_capture_ext (UPPER_W = 16).
module tb_cnt_capture_ext;

    logic        CLK = 1'b0;
    logic        CD;
    logic [15:0] Q_LO;
    logic        CAO;
    logic        CAPT;
    logic [31:0] DOUT;
    logic        DVALID;
    logic        DREADY;
    logic        LOST;
    logic        CLR_LOST;
    logic [15:0] HI;
`ifdef CNT_CAPTURE_EXT_OVF_EN
    logic        OVF;
    logic        CLR_OVF;
`endif

    int n_pass  = 0;
    int n_total = 0;

    cnt_capture_ext #(
        .UPPER_W (16)
    ) dut (
        .CLK      (CLK),
        .CD       (CD),
        .Q_LO     (Q_LO),
        .CAO      (CAO),
        .CAPT     (CAPT),
        .DOUT     (DOUT),
        .DVALID   (DVALID),
        .DREADY   (DREADY),
        .LOST     (LOST),
        .CLR_LOST (CLR_LOST),
`ifdef CNT_CAPTURE_EXT_OVF_EN
        .OVF      (OVF),
        .CLR_OVF  (CLR_OVF),
`endif
        .HI       (HI)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        CD = 1'b1; Q_LO = 16'h1234; CAO = 1'b1; CAPT = 1'b1;
        DREADY = 1'b0; CLR_LOST = 1'b0;
`ifdef CNT_CAPTURE_EXT_OVF_EN
        CLR_OVF = 1'b1;
`endif
        #1;
        step(); step();
        chk("rst_hi",     HI,     16'h0);
        chk("rst_dvalid", DVALID, 1'b0);
        chk("rst_lost",   LOST,   1'b0);
        chk("rst_dout",   DOUT,   32'h0);
`ifdef CNT_CAPTURE_EXT_OVF_EN
        chk("rst_ovf",    OVF,    1'b0);
        CLR_OVF = 1'b0;
`endif

        // Bring HI to 3 with three carry cycles, then hold.
        CD = 1'b0; CAPT = 1'b0; CAO = 1'b1;
        step(); step(); step();
        CAO = 1'b0;
        step();
        chk("hi_hold3", HI, 16'h0003);

        // Capture in the carry cycle and the cycle after.
        Q_LO = 16'hFFFF; CAO = 1'b1; CAPT = 1'b1; DREADY = 1'b1;
        step();
        chk("carry_hi",     HI,     16'h0004);
        chk("carry_dout0",  DOUT,   32'h0003FFFF);
        chk("carry_valid0", DVALID, 1'b1);
        Q_LO = 16'h0000; CAO = 1'b0;
        step();
        chk("carry_dout1",  DOUT,   32'h00040000);
        chk("carry_valid1", DVALID, 1'b1);
        CAPT = 1'b0;
        step();
        chk("drain_valid",  DVALID, 1'b0);
        chk("drain_dout",   DOUT,   32'h00040000);

        // Clean reset so HI=0 for the back-pressure vectors.
        CD = 1'b1;
        step();
        CD = 1'b0;
        chk("rst2_hi", HI, 16'h0);

        Q_LO = 16'h0010; CAPT = 1'b1; DREADY = 1'b0;
        step();
        chk("bp_dout0",  DOUT,   32'h00000010);
        chk("bp_valid0", DVALID, 1'b1);
        chk("bp_lost0",  LOST,   1'b0);
        Q_LO = 16'h0012;
        step();
        chk("bp_dout1",  DOUT,   32'h00000010);
        chk("bp_lost1",  LOST,   1'b1);
        CAPT = 1'b0; CLR_LOST = 1'b1;
        step();
        chk("bp_clr",    LOST,   1'b0);
        chk("bp_valid2", DVALID, 1'b1);
        CAPT = 1'b1;
        step();
        chk("lost_setwins", LOST, 1'b1);
        CAPT = 1'b0;
        step();
        chk("lost_clr2", LOST, 1'b0);
        CLR_LOST = 1'b0;

        // Accept and capture in the same cycle, then plain accept.
        Q_LO = 16'h0100; CAPT = 1'b1; DREADY = 1'b1;
        step();
        chk("acc_cap_valid", DVALID, 1'b1);
        chk("acc_cap_dout",  DOUT,   32'h00000100);
        CAPT = 1'b0;
        step();
        chk("acc_valid", DVALID, 1'b0);
        chk("acc_dout",  DOUT,   32'h00000100);

        // Reset while a snapshot is pending and back-pressured.
        Q_LO = 16'h0055; CAPT = 1'b1; DREADY = 1'b0;
        step();
        chk("mid_valid0", DVALID, 1'b1);
        chk("mid_dout0",  DOUT,   32'h00000055);
        Q_LO = 16'h0066;
        step();
        chk("mid_lost", LOST, 1'b1);
        CD = 1'b1; DREADY = 1'b1;
        step();
        chk("mid_valid1", DVALID, 1'b0);
        chk("mid_dout1",  DOUT,   32'h0);
        chk("mid_lost1",  LOST,   1'b0);
        CD = 1'b0; CAPT = 1'b0; DREADY = 1'b0;
        step();
        chk("mid_valid2", DVALID, 1'b0);

        // Full upper-counter wrap.
        CAO = 1'b1;
        for (int i = 0; i < 65535; i++) step();
        chk("wrap_ffff", HI, 16'hFFFF);
`ifdef CNT_CAPTURE_EXT_OVF_EN
        chk("ovf_pre", OVF, 1'b0);
`endif
        step();
        CAO = 1'b0;
        chk("wrap_zero", HI, 16'h0000);
`ifdef CNT_CAPTURE_EXT_OVF_EN
        chk("ovf_set", OVF, 1'b1);
        step();
        chk("ovf_sticky", OVF, 1'b1);
        CLR_OVF = 1'b1;
        step();
        CLR_OVF = 1'b0;
        chk("ovf_clr", OVF, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
